// File: rtl/btn_pkg.sv
// Shared types and widths for the button conditioner: channel FSM states and counter widths.
package btn_pkg;

    typedef enum logic [1:0] {
        REL     = 2'd0,
        PRS_CHK = 2'd1,
        PRSD    = 2'd2,
        REL_CHK = 2'd3
    } btn_state_t;

    localparam int unsigned DBC_W  = 8;
    localparam int unsigned HOLD_W = 16;

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle: raw active-low buttons in, debounced levels and press pulses out.
interface button_conditioner_if;

    logic Toggle_i;
    logic Push_i;
    logic Toggle_o;
    logic Push_o;
    logic Toggle_p;
    logic Push_p;

    modport master (
        output Toggle_i, Push_i,
        input  Toggle_o, Push_o, Toggle_p, Push_p
    );

    modport slave (
        input  Toggle_i, Push_i,
        output Toggle_o, Push_o, Toggle_p, Push_p
    );

endinterface

// File: rtl/btn_channel.sv
// One button: synchroniser, four-state debounce FSM, press pulse and, under LONG_PRESS_EN
// with REPEAT_EN set, a hold/auto-repeat pulse generator.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned HOLD_CNT     = 20,
    parameter int unsigned REPEAT_CNT   = 10,
    parameter bit          REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   smp;
    btn_state_t             state_q, state_d;
    logic [DBC_W-1:0]       dbc_q, dbc_d, dbc_inc;
    logic                   press_d;
    logic                   rep_fire;
    logic                   unused_cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign smp     = sync_q[SYNC_STAGES-1];
    assign dbc_inc = (dbc_q == '1) ? dbc_q : dbc_q + DBC_W'(1);

    // The sample that leaves a stable state counts as the first of DEBOUNCE_CNT candidate samples.
    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        press_d = 1'b0;
        case (state_q)
            REL: if (!smp) begin
                state_d = PRS_CHK;
                dbc_d   = DBC_W'(1);
            end
            PRS_CHK: begin
                if (smp) begin
                    state_d = REL;
                    dbc_d   = '0;
                end else if (dbc_q >= DBC_LAST) begin
                    state_d = PRSD;
                    dbc_d   = '0;
                    press_d = 1'b1;
                end else begin
                    dbc_d = dbc_inc;
                end
            end
            PRSD: if (smp) begin
                state_d = REL_CHK;
                dbc_d   = DBC_W'(1);
            end
            REL_CHK: begin
                if (!smp) begin
                    state_d = PRSD;
                    dbc_d   = '0;
                end else if (dbc_q >= DBC_LAST) begin
                    state_d = REL;
                    dbc_d   = '0;
                end else begin
                    dbc_d = dbc_inc;
                end
            end
            default: begin
                state_d = REL;
                dbc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REL;
            dbc_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
            pulse   <= press_d | rep_fire;
        end
    end

    assign level = !((state_q == PRSD) || (state_q == REL_CHK));

`ifdef LONG_PRESS_EN
    generate
        if (REPEAT_EN) begin : g_rep
            logic [HOLD_W-1:0] hold_q, hold_inc;
            logic              rep_q, stay;

            assign stay     = (state_q == PRSD) && (state_d == PRSD);
            assign hold_inc = hold_q + HOLD_W'(1);
            assign rep_fire = stay && (rep_q ? (hold_inc == HOLD_W'(REPEAT_CNT))
                                             : (hold_inc == HOLD_W'(HOLD_CNT)));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                    rep_q  <= 1'b0;
                end else if (!stay) begin
                    hold_q <= '0;
                    rep_q  <= 1'b0;
                end else if (rep_fire) begin
                    hold_q <= '0;
                    rep_q  <= 1'b1;
                end else begin
                    hold_q <= hold_inc;
                end
            end
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end
    endgenerate
`else
    assign rep_fire = 1'b0;
`endif

    assign unused_cfg = ^{REPEAT_EN, HOLD_W'(HOLD_CNT), HOLD_W'(REPEAT_CNT)};

endmodule

// File: rtl/button_conditioner.sv
// Two-button conditioner (Toggle, Push) feeding the master counter; define LONG_PRESS_EN
// to give the Push channel hold/auto-repeat pulses.
module button_conditioner #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned HOLD_CNT     = 20,
    parameter int unsigned REPEAT_CNT   = 10
) (
    input logic                 Clk,
    input logic                 Rst,
    button_conditioner_if.slave bus
);

    btn_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .HOLD_CNT    (HOLD_CNT),
        .REPEAT_CNT  (REPEAT_CNT),
        .REPEAT_EN   (1'b0)
    ) u_toggle (
        .clk  (Clk),
        .rst_n(Rst),
        .raw  (bus.Toggle_i),
        .level(bus.Toggle_o),
        .pulse(bus.Toggle_p)
    );

    btn_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .HOLD_CNT    (HOLD_CNT),
        .REPEAT_CNT  (REPEAT_CNT),
        .REPEAT_EN   (1'b1)
    ) u_push (
        .clk  (Clk),
        .rst_n(Rst),
        .raw  (bus.Push_i),
        .level(bus.Push_o),
        .pulse(bus.Push_p)
    );

endmodule
